// File: rtl/divisor_resultado_buffer.sv
// Result buffer behind the pipelined divider: in-order FIFO of {quotient, remainder}
// with a valid/ready output and an issue credit that reserves a slot per division in flight.
module divisor_resultado_buffer #(
    parameter int tamanyo     = 32,
    parameter int PROFUNDIDAD = 8,
    parameter int ENVUELO_W   = $clog2(PROFUNDIDAD + 2 * tamanyo + 2)
) (
    input  logic                                 CLK,
    input  logic                                 RSTa,
    input  logic                                 Start,
    input  logic                                 Done,
    input  logic signed [tamanyo-1:0]            Coc,
    input  logic signed [tamanyo-1:0]            Res,
    output logic                                 Out_Valid,
    input  logic                                 Out_Ready,
    output logic signed [tamanyo-1:0]            Out_Coc,
    output logic signed [tamanyo-1:0]            Out_Res,
    output logic                                 Can_Start,
    output logic [$clog2(PROFUNDIDAD+1)-1:0]     Count,
    output logic                                 Overflow,
    output logic                                 Err_Protocolo
);

    localparam int PTR_W = $clog2(PROFUNDIDAD);
    localparam int CNT_W = $clog2(PROFUNDIDAD + 1);
    localparam int SUM_W = ENVUELO_W + 1;

    localparam logic [CNT_W-1:0]     LLENO   = CNT_W'(PROFUNDIDAD);
    localparam logic [ENVUELO_W-1:0] ENV_MAX = '1;
    localparam logic [SUM_W-1:0]     LIMITE  = SUM_W'(PROFUNDIDAD);

    typedef struct packed {
        logic signed [tamanyo-1:0] coc;
        logic signed [tamanyo-1:0] res;
    } entrada_t;

    entrada_t mem_q [PROFUNDIDAD];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ENVUELO_W-1:0] envuelo_q, envuelo_d;
    logic                 overflow_q, overflow_d;
    logic                 err_q, err_d;

    logic                 vacio;
    logic                 lleno;
    logic                 pop;
    logic                 wr_acc;
    logic                 descarte;
    logic                 err_evt;
    logic [SUM_W-1:0]     ocupacion;

    // Saturating in-flight update; Start and Done together cancel out.
    function automatic logic [ENVUELO_W-1:0] envuelo_sig(
        input logic [ENVUELO_W-1:0] e,
        input logic                 inc,
        input logic                 dec
    );
        if (inc && !dec)
            return (e == ENV_MAX) ? e : e + 1'b1;
        if (dec && !inc)
            return (e == '0) ? e : e - 1'b1;
        return e;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_sig(input logic [PTR_W-1:0] p);
        return p + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] count_sig(
        input logic [CNT_W-1:0] c,
        input logic             wr,
        input logic             rd
    );
        if (wr && !rd)
            return c + 1'b1;
        if (rd && !wr)
            return c - 1'b1;
        return c;
    endfunction

    always_comb begin
        vacio    = (count_q == '0);
        lleno    = (count_q == LLENO);
        pop      = !vacio && Out_Ready;
        // A full FIFO still takes a result when the head leaves on the same edge.
        wr_acc   = Done && (!lleno || pop);
        descarte = Done && lleno && !pop;
        err_evt  = Done && !Start && (envuelo_q == '0);
    end

    always_comb begin
        wr_ptr_d   = wr_acc ? ptr_sig(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop    ? ptr_sig(rd_ptr_q) : rd_ptr_q;
        count_d    = count_sig(count_q, wr_acc, pop);
        envuelo_d  = envuelo_sig(envuelo_q, Start, Done);
        overflow_d = overflow_q | descarte;
        err_d      = err_q | err_evt;
    end

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            envuelo_q  <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            envuelo_q  <= envuelo_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    // Storage is data only; validity is carried entirely by the pointers and count.
    always_ff @(posedge CLK) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= '{coc: Coc, res: Res};
    end

    always_comb begin
        ocupacion     = SUM_W'(count_q) + SUM_W'(envuelo_q);
        Can_Start     = (ocupacion < LIMITE);
        Out_Valid     = !vacio;
        Out_Coc       = vacio ? '0 : mem_q[rd_ptr_q].coc;
        Out_Res       = vacio ? '0 : mem_q[rd_ptr_q].res;
        Count         = count_q;
        Overflow      = overflow_q;
        Err_Protocolo = err_q;
    end

endmodule

// File: tb/tb_divisor_resultado_buffer.sv
// Directed bench for divisor_resultado_buffer: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every handshake.
module tb_divisor_resultado_buffer;

    localparam int W = 32;
    localparam int D = 8;

    logic                         CLK = 1'b0;
    logic                         RSTa;
    logic                         Start;
    logic                         Done;
    logic [W-1:0]                 Coc;
    logic [W-1:0]                 Res;
    logic                         Out_Valid;
    logic                         Out_Ready;
    logic [W-1:0]                 Out_Coc;
    logic [W-1:0]                 Out_Res;
    logic                         Can_Start;
    logic [$clog2(D+1)-1:0]       Count;
    logic                         Overflow;
    logic                         Err_Protocolo;

    divisor_resultado_buffer #(.tamanyo(W), .PROFUNDIDAD(D)) dut (
        .CLK(CLK), .RSTa(RSTa), .Start(Start), .Done(Done), .Coc(Coc), .Res(Res),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Coc(Out_Coc), .Out_Res(Out_Res),
        .Can_Start(Can_Start), .Count(Count), .Overflow(Overflow), .Err_Protocolo(Err_Protocolo)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] coc;
        logic [W-1:0] res;
    } par_t;

    par_t sb[$];
    par_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Hand-computed signed divisions, truncating quotient, remainder takes the dividend's sign:
    // 17/5, -17/5, 17/-5, -17/-5, 0/3, 1000/7, -1/1, 2147483647/2
    logic [W-1:0] ctab [D] = '{32'h3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h3,
                               32'h0, 32'h8E, 32'hFFFFFFFF, 32'h3FFFFFFF};
    logic [W-1:0] rtab [D] = '{32'h2, 32'hFFFFFFFE, 32'h2, 32'hFFFFFFFE,
                               32'h0, 32'h6, 32'h0, 32'h1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic done_push(input logic [W-1:0] c, input logic [W-1:0] r, input bit stored);
        Done = 1'b1;
        Coc  = c;
        Res  = r;
        if (stored)
            sb.push_back('{c, r});
        step();
        Done = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RSTa && Out_Valid && Out_Ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got coc %0h res %0h, want no entry", Out_Coc, Out_Res);
            end else begin
                mon_e = sb.pop_front();
                if (Out_Coc !== mon_e.coc || Out_Res !== mon_e.res) begin
                    n_fail++;
                    $display("FAIL pop_data: got coc %0h res %0h, want coc %0h res %0h",
                             Out_Coc, Out_Res, mon_e.coc, mon_e.res);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        RSTa = 1'b1; Start = 1'b0; Done = 1'b0; Out_Ready = 1'b0; Coc = '0; Res = '0;
        repeat (3) step();
        chk("rst_valid", Out_Valid, 0);
        chk("rst_count", Count, 0);
        chk("rst_can_start", Can_Start, 1);
        chk("rst_coc", Out_Coc, 0);
        RSTa = 1'b0;
        step();

        // Single result, Done 65 cycles after Start
        Start = 1'b1; step(); Start = 1'b0;
        repeat (64) step();
        Done = 1'b1; Coc = 32'hFFFFFFFD; Res = 32'hFFFFFFFF;
        sb.push_back('{32'hFFFFFFFD, 32'hFFFFFFFF});
        #1;
        chk("no_comb_path_valid", Out_Valid, 0);
        step(); Done = 1'b0;
        chk("single_valid", Out_Valid, 1);
        chk("single_coc", Out_Coc, 32'hFFFFFFFD);
        chk("single_res", Out_Res, 32'hFFFFFFFF);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", Out_Valid, 1);
            chk("hold_coc", Out_Coc, 32'hFFFFFFFD);
        end
        Out_Ready = 1'b1; step(); Out_Ready = 1'b0;
        chk("single_drained_valid", Out_Valid, 0);
        chk("single_drained_count", Count, 0);
        chk("single_drained_coc", Out_Coc, 0);

        // Credit: issue while allowed, with the consumer stalled
        n = 0;
        for (int i = 0; i < 20 && Can_Start; i++) begin
            Start = 1'b1; step(); n++;
        end
        Start = 1'b0;
        chk("credit_starts", n, 8);
        chk("credit_exhausted", Can_Start, 0);
        for (int i = 0; i < D; i++)
            done_push(ctab[i], rtab[i], 1'b1);
        chk("full_count", Count, 8);
        chk("full_overflow", Overflow, 0);
        chk("full_can_start", Can_Start, 0);
        Out_Ready = 1'b1; step(); Out_Ready = 1'b0;
        chk("pop_frees_credit", Can_Start, 1);
        chk("pop_count", Count, 7);

        // Refill to full, then Done with a simultaneous pop
        Start = 1'b1; step(); Start = 1'b0;
        chk("credit_reserved", Can_Start, 0);
        done_push(32'h7, 32'h1, 1'b1);
        chk("refill_count", Count, 8);
        Start = 1'b1; step(); Start = 1'b0;
        Out_Ready = 1'b1;
        done_push(32'h5, 32'h0, 1'b1);
        Out_Ready = 1'b0;
        chk("simul_count", Count, 8);
        chk("simul_overflow", Overflow, 0);

        // Overflow: forced Start while full, result 100/10 must be dropped
        Start = 1'b1; step(); Start = 1'b0;
        done_push(32'hA, 32'h0, 1'b0);
        chk("ovf_flag", Overflow, 1);
        chk("ovf_count", Count, 8);
        chk("ovf_err", Err_Protocolo, 0);

        for (int i = 0; i < 20 && Out_Valid; i++) begin
            Out_Ready = 1'b1; step();
        end
        Out_Ready = 1'b0;
        chk("drain_empty", Out_Valid, 0);
        chk("drain_sb_left", sb.size(), 0);
        chk("drain_count", Count, 0);
        chk("ovf_sticky", Overflow, 1);
        chk("drain_can_start", Can_Start, 1);

        // Asynchronous reset mid-traffic
        Start = 1'b1; step(); Start = 1'b0;
        done_push(32'h11, 32'h22, 1'b1);
        Start = 1'b1; step();
        #2 RSTa = 1'b1;
        sb.delete();
        Start = 1'b0;
        #1;
        chk("async_rst_valid", Out_Valid, 0);
        chk("async_rst_count", Count, 0);
        chk("async_rst_overflow", Overflow, 0);
        chk("async_rst_can_start", Can_Start, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold_coc", Out_Coc, 0);
            chk("rst_hold_err", Err_Protocolo, 0);
        end
        RSTa = 1'b0;
        step();
        chk("post_rst_valid", Out_Valid, 0);
        chk("post_rst_count", Count, 0);
        chk("post_rst_overflow", Overflow, 0);
        chk("post_rst_can_start", Can_Start, 1);

        // Protocol error: Done with nothing in flight is still stored
        done_push(32'h63, 32'hFFFFFFFD, 1'b1);
        chk("proto_err", Err_Protocolo, 1);
        chk("proto_count", Count, 1);
        chk("proto_coc", Out_Coc, 32'h63);
        n = 0;
        for (int i = 0; i < 20 && Can_Start; i++) begin
            Start = 1'b1; step(); n++;
        end
        Start = 1'b0;
        chk("proto_envuelo_zero", n, 7);
        Out_Ready = 1'b1; step(); Out_Ready = 1'b0;
        chk("proto_drained", Count, 0);
        chk("proto_sb_left", sb.size(), 0);
        chk("proto_err_sticky", Err_Protocolo, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
